// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM encoding, widths, frame-length helpers.
// Used by both the receive and transmit engines.
package uart_pkg;

    localparam int unsigned K_W   = 19;
    localparam int unsigned SR_W  = 10;
    localparam int unsigned CNT_W = 4;
    localparam int unsigned BITS7 = 7;
    localparam int unsigned BITS8 = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2
    } uart_state_e;

    function automatic logic [CNT_W-1:0] data_bits(input logic eight);
        return eight ? CNT_W'(BITS8) : CNT_W'(BITS7);
    endfunction

    // Bits after the start bit: data + optional parity + stop.
    function automatic logic [CNT_W-1:0] frame_len(input logic eight, input logic pen);
        return data_bits(eight) + CNT_W'(pen) + CNT_W'(1);
    endfunction

endpackage

// File: rtl/bit_timer.sv
// Bit-time counter: pulses tick after k cycles, or k>>1 cycles when half=1.
// Counter is held at zero while run is low and reloads on every tick.
module bit_timer
    import uart_pkg::*;
(
    input  logic           clk,
    input  logic           rst,
    input  logic           run,
    input  logic           half,
    input  logic [K_W-1:0] k,
    output logic           tick
);

    logic [K_W-1:0] r_cnt;
    logic [K_W-1:0] w_term;

    assign w_term = half ? (k >> 1) : k;
    assign tick   = run && (r_cnt == (w_term - K_W'(1)));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt <= '0;
        end else if (!run || tick) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + K_W'(1);
        end
    end

endmodule

// File: rtl/uart_rx_engine.sv
// UART receive engine: synchronizes rx, finds start bits, deserializes
// 7/8-bit frames with optional parity and reports data plus status flags.
module uart_rx_engine
    import uart_pkg::*;
(
    input  logic           clk,
    input  logic           rst,
    input  logic           rx,
    input  logic           eight,
    input  logic           pen,
    input  logic           ohel,
    input  logic [K_W-1:0] k,
    input  logic           clr,
    output logic [7:0]     data,
    output logic           rx_rdy,
    output logic           perr,
    output logic           ferr,
    output logic           ovf
);

    logic              r_sync1, r_sync2;
    uart_state_e       r_state, w_state_nx;
    logic              r_eight, r_pen, r_ohel;
    logic [K_W-1:0]    r_k;
    logic [CNT_W-1:0]  r_bitcnt;
    logic [SR_W-1:0]   r_sr;
    logic [7:0]        r_data;
    logic              r_rx_rdy, r_perr, r_ferr, r_ovf;

    logic              w_rx, w_run, w_half, w_tick;
    logic              w_start_go, w_shift, w_done;
    logic [CNT_W-1:0]  w_nbits;
    logic [SR_W:0]     w_word, w_frame;
    logic [7:0]        w_data;
    logic              w_par, w_stop, w_perr;

    assign w_rx    = r_sync2;
    assign w_run   = (r_state != ST_IDLE);
    assign w_half  = (r_state == ST_START);
    assign w_nbits = frame_len(r_eight, r_pen);

    bit_timer u_bit_timer (
        .clk  (clk),
        .rst  (rst),
        .run  (w_run),
        .half (w_half),
        .k    (r_k),
        .tick (w_tick)
    );

    // Earlier samples plus the stop sample, realigned so data bit 0 sits at bit 0.
    assign w_word  = {w_rx, r_sr};
    assign w_frame = w_word >> (CNT_W'(SR_W + 1) - w_nbits);
    assign w_data  = {r_eight & w_frame[7], w_frame[6:0]};
    assign w_par   = w_frame[w_nbits - CNT_W'(2)];
    assign w_stop  = w_frame[w_nbits - CNT_W'(1)];
    assign w_perr  = r_pen & ((^w_data) ^ w_par ^ r_ohel);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nx;
        end
    end

    always_comb begin
        w_state_nx = r_state;
        w_start_go = 1'b0;
        w_shift    = 1'b0;
        w_done     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (!w_rx) begin
                    w_state_nx = ST_START;
                    w_start_go = 1'b1;
                end
            end
            ST_START: begin
                if (w_tick) begin
                    w_state_nx = w_rx ? ST_IDLE : ST_DATA;
                end
            end
            ST_DATA: begin
                if (w_tick) begin
                    w_shift = 1'b1;
                    if (r_bitcnt == (w_nbits - CNT_W'(1))) begin
                        w_done     = 1'b1;
                        w_state_nx = ST_IDLE;
                    end
                end
            end
            default: w_state_nx = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_sync1  <= 1'b1;
            r_sync2  <= 1'b1;
            r_eight  <= 1'b0;
            r_pen    <= 1'b0;
            r_ohel   <= 1'b0;
            r_k      <= '0;
            r_bitcnt <= '0;
            r_sr     <= '0;
        end else begin
            r_sync1 <= rx;
            r_sync2 <= r_sync1;
            if (w_start_go) begin
                r_eight <= eight;
                r_pen   <= pen;
                r_ohel  <= ohel;
                r_k     <= k;
            end
            if (r_state != ST_DATA) begin
                r_bitcnt <= '0;
            end else if (w_shift) begin
                r_bitcnt <= r_bitcnt + CNT_W'(1);
            end
            if (w_shift) begin
                r_sr <= {w_rx, r_sr[SR_W-1:1]};
            end
        end
    end

    // Frame completion takes priority over a simultaneous clear.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_data   <= '0;
            r_rx_rdy <= 1'b0;
            r_perr   <= 1'b0;
            r_ferr   <= 1'b0;
            r_ovf    <= 1'b0;
        end else if (w_done) begin
            r_data   <= w_data;
            r_rx_rdy <= 1'b1;
            r_perr   <= w_perr;
            r_ferr   <= ~w_stop;
            r_ovf    <= r_rx_rdy & ~clr;
        end else if (clr) begin
            r_rx_rdy <= 1'b0;
            r_perr   <= 1'b0;
            r_ferr   <= 1'b0;
            r_ovf    <= 1'b0;
        end
    end

    assign data   = r_data;
    assign rx_rdy = r_rx_rdy;
    assign perr   = r_perr;
    assign ferr   = r_ferr;
    assign ovf    = r_ovf;

endmodule

// File: tb/tb_uart_rx_engine.sv
// Testbench for uart_rx_engine: directed scenarios plus randomized frames
// checked against a frame-level reference model.
module tb_uart_rx_engine;

    logic        clk   = 1'b0;
    logic        rst   = 1'b0;
    logic        rx    = 1'b1;
    logic        eight = 1'b1;
    logic        pen   = 1'b0;
    logic        ohel  = 1'b0;
    logic        clr   = 1'b0;
    logic [18:0] k     = 19'd16;
    logic [7:0]  data;
    logic        rx_rdy, perr, ferr, ovf;

    int total = 0;
    int bad   = 0;

    logic [7:0] m_data = 8'h00;
    logic       m_rdy  = 1'b0;
    logic       m_perr = 1'b0;
    logic       m_ferr = 1'b0;
    logic       m_ovf  = 1'b0;

    uart_rx_engine dut (
        .clk    (clk),
        .rst    (rst),
        .rx     (rx),
        .eight  (eight),
        .pen    (pen),
        .ohel   (ohel),
        .k      (k),
        .clr    (clr),
        .data   (data),
        .rx_rdy (rx_rdy),
        .perr   (perr),
        .ferr   (ferr),
        .ovf    (ovf)
    );

    always #5 clk = ~clk;

    function automatic logic [11:0] exp_vec();
        return {m_data, m_rdy, m_perr, m_ferr, m_ovf};
    endfunction

    // Drives one whole frame; optionally pulses clr in the completion cycle.
    task automatic send_frame(input logic [7:0] d, input logic ei, input logic pe,
                              input logic oh, input logic bad_par, input logic stop,
                              input int kk, input logic doclr);
        logic       bits [0:10];
        logic [7:0] dm;
        logic       par;
        int         nb;
        dm = ei ? d : {1'b0, d[6:0]};
        par = (^dm) ^ oh ^ bad_par;
        nb = 0;
        bits[nb] = 1'b0; nb = nb + 1;
        for (int i = 0; i < (ei ? 8 : 7); i++) begin
            bits[nb] = dm[i]; nb = nb + 1;
        end
        if (pe) begin
            bits[nb] = par; nb = nb + 1;
        end
        bits[nb] = stop; nb = nb + 1;
        eight = ei; pen = pe; ohel = oh; k = 19'(kk);
        for (int c = 0; c < nb * kk; c++) begin
            @(posedge clk); #1;
            rx  = bits[c / kk];
            clr = doclr && (c == 2 + kk / 2 + (nb - 1) * kk);
        end
        @(posedge clk); #1;
        rx = 1'b1; clr = 1'b0;
        m_ovf  = m_rdy & ~doclr;
        m_data = dm;
        m_perr = pe & bad_par;
        m_ferr = ~stop;
        m_rdy  = 1'b1;
        repeat (stop ? 4 : kk + 4) @(posedge clk);
    endtask

    task automatic pulse_clr();
        @(posedge clk); #1 clr = 1'b1;
        @(posedge clk); #1 clr = 1'b0;
        m_rdy = 1'b0; m_perr = 1'b0; m_ferr = 1'b0; m_ovf = 1'b0;
    endtask

    task automatic test_reset();
        #2;
        total++;
        if ({data, rx_rdy, perr, ferr, ovf} !== 12'h000) begin
            bad++; $display("FAIL reset_state: got %h expected %h", {data, rx_rdy, perr, ferr, ovf}, 12'h000);
        end
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        repeat (4) @(posedge clk);
    endtask

    task automatic test_8n1();
        send_frame(8'hA5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 16, 1'b0);
        @(negedge clk); total++;
        if ({data, rx_rdy, perr, ferr, ovf} !== exp_vec()) begin
            bad++; $display("FAIL 8n1_a5: got %h expected %h", {data, rx_rdy, perr, ferr, ovf}, exp_vec());
        end
        pulse_clr();
        @(negedge clk); total++;
        if ({data, rx_rdy, perr, ferr, ovf} !== exp_vec()) begin
            bad++; $display("FAIL clr_8n1: got %h expected %h", {data, rx_rdy, perr, ferr, ovf}, exp_vec());
        end
    endtask

    task automatic test_parity();
        send_frame(8'h41, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 16, 1'b0);
        @(negedge clk); total++;
        if ({data, rx_rdy, perr, ferr, ovf} !== exp_vec()) begin
            bad++; $display("FAIL 7e1_good: got %h expected %h", {data, rx_rdy, perr, ferr, ovf}, exp_vec());
        end
        pulse_clr();
        send_frame(8'h41, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 16, 1'b0);
        @(negedge clk); total++;
        if ({data, rx_rdy, perr, ferr, ovf} !== exp_vec()) begin
            bad++; $display("FAIL 7e1_bad: got %h expected %h", {data, rx_rdy, perr, ferr, ovf}, exp_vec());
        end
        pulse_clr();
    endtask

    task automatic test_framing();
        send_frame(8'h00, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 16, 1'b0);
        @(negedge clk); total++;
        if ({data, rx_rdy, perr, ferr, ovf} !== exp_vec()) begin
            bad++; $display("FAIL 8o1_ferr: got %h expected %h", {data, rx_rdy, perr, ferr, ovf}, exp_vec());
        end
        pulse_clr();
        send_frame(8'h3C, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 16, 1'b0);
        @(negedge clk); total++;
        if ({data, rx_rdy, perr, ferr, ovf} !== exp_vec()) begin
            bad++; $display("FAIL 8o1_resync: got %h expected %h", {data, rx_rdy, perr, ferr, ovf}, exp_vec());
        end
    endtask

    task automatic test_overflow();
        pulse_clr();
        send_frame(8'h11, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 16, 1'b0);
        send_frame(8'h22, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 16, 1'b0);
        @(negedge clk); total++;
        if ({data, rx_rdy, perr, ferr, ovf} !== exp_vec()) begin
            bad++; $display("FAIL ovf_set: got %h expected %h", {data, rx_rdy, perr, ferr, ovf}, exp_vec());
        end
        send_frame(8'h33, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 16, 1'b1);
        @(negedge clk); total++;
        if ({data, rx_rdy, perr, ferr, ovf} !== exp_vec()) begin
            bad++; $display("FAIL clr_vs_done: got %h expected %h", {data, rx_rdy, perr, ferr, ovf}, exp_vec());
        end
    endtask

    task automatic test_false_start();
        pulse_clr();
        k = 19'd16;
        for (int c = 0; c < 6; c++) begin
            @(posedge clk); #1 rx = 1'b0;
        end
        @(posedge clk); #1 rx = 1'b1;
        repeat (40) @(posedge clk);
        @(negedge clk); total++;
        if ({data, rx_rdy, perr, ferr, ovf} !== exp_vec()) begin
            bad++; $display("FAIL false_start: got %h expected %h", {data, rx_rdy, perr, ferr, ovf}, exp_vec());
        end
    endtask

    task automatic test_reset_mid();
        logic [7:0] d;
        d = 8'h96;
        eight = 1'b1; pen = 1'b0; k = 19'd16;
        for (int c = 0; c < 5 * 16; c++) begin
            @(posedge clk); #1;
            rx = (c < 16) ? 1'b0 : d[c / 16 - 1];
        end
        @(posedge clk); #1;
        rst = 1'b0; rx = 1'b1;
        m_data = 8'h00; m_rdy = 1'b0; m_perr = 1'b0; m_ferr = 1'b0; m_ovf = 1'b0;
        #1 total++;
        if ({data, rx_rdy, perr, ferr, ovf} !== exp_vec()) begin
            bad++; $display("FAIL reset_mid: got %h expected %h", {data, rx_rdy, perr, ferr, ovf}, exp_vec());
        end
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        repeat (4) @(posedge clk);
        send_frame(8'h5A, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 16, 1'b0);
        @(negedge clk); total++;
        if ({data, rx_rdy, perr, ferr, ovf} !== exp_vec()) begin
            bad++; $display("FAIL after_reset_5a: got %h expected %h", {data, rx_rdy, perr, ferr, ovf}, exp_vec());
        end
    endtask

    task automatic test_random();
        logic [7:0] d;
        logic       ei, pe, oh, bp, dc;
        int         kk;
        for (int i = 0; i < 24; i++) begin
            d  = 8'($urandom);
            ei = 1'($urandom_range(0, 1));
            pe = 1'($urandom_range(0, 1));
            oh = 1'($urandom_range(0, 1));
            bp = 1'($urandom_range(0, 1));
            dc = ($urandom_range(0, 3) == 0);
            kk = int'($urandom_range(12, 40));
            send_frame(d, ei, pe, oh, bp, 1'b1, kk, dc);
            @(negedge clk); total++;
            if ({data, rx_rdy, perr, ferr, ovf} !== exp_vec()) begin
                bad++; $display("FAIL random_%0d: got %h expected %h (k=%0d e=%0b p=%0b o=%0b)",
                                i, {data, rx_rdy, perr, ferr, ovf}, exp_vec(), kk, ei, pe, oh);
            end
            if ($urandom_range(0, 1) == 1) begin
                pulse_clr();
                @(negedge clk); total++;
                if ({data, rx_rdy, perr, ferr, ovf} !== exp_vec()) begin
                    bad++; $display("FAIL random_clr_%0d: got %h expected %h", i, {data, rx_rdy, perr, ferr, ovf}, exp_vec());
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_8n1();
        test_parity();
        test_framing();
        test_overflow();
        test_false_start();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
